f_fetch_ctrl: RTL and testbench
===============================

Name: f_fetch_ctrl

Overview:
- F-stage fetch sequencer. Owns the F_pc register and issues instruction-memory requests over a req/ack handshake.
- Holds the fetched word until D accepts it, then advances F_pc to the npc produced by the D-stage next-PC logic.
- A flush/redirect from later pipeline stages (exception entry, eret) overrides the normal sequence.
- Sits between the next-PC logic, the hazard unit (stall) and instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, F_pc value loaded on reset.
- IM_SIZE, 32'h0000_4000, byte span of valid instruction space starting at RESET_PC; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: D cannot accept this cycle.
- npc  in  32  next PC from the next-PC logic; must be stable whenever F_valid=1.
- flush  in  1  redirect request from a later stage.
- flush_pc  in  32  redirect target; sampled only when flush=1.
- im_req  out  1  instruction-memory request, registered.
- im_addr  out  32  request address, registered.
- im_ack  in  1  memory completes the request this cycle.
- im_rdata  in  32  instruction word; valid when im_ack=1.
- F_pc  out  32  PC of the instruction presented to D.
- F_instr  out  32  instruction presented to D.
- F_valid  out  1  F_instr/F_pc are valid for D.
- F_exc  out  5  fetch exception code (0 = none).

Behaviour:
- Reset (async assert, sync release): state=S_IDLE, F_pc=RESET_PC, im_addr=RESET_PC, im_req=0, F_instr=0, F_valid=0, F_exc=0.
- accept = F_valid & ~stall & ~flush. A flush always masks accept.
- Handshake rule: once im_req=1, im_req and im_addr stay stable until the cycle im_ack=1. im_ack while im_req=0 is ignored.
- S_IDLE (one cycle after reset release): im_req<=1, im_addr<=F_pc, go to S_REQ. If flush: F_pc<=flush_pc, im_addr<=flush_pc.
- S_REQ:
  - im_ack & ~flush: F_instr<=im_rdata, F_valid<=1, im_req<=0, go to S_HOLD.
  - im_ack & flush: discard the data; F_pc<=flush_pc, im_addr<=flush_pc, im_req stays 1, stay in S_REQ.
  - ~im_ack & flush: F_pc<=flush_pc; im_addr unchanged; go to S_DRAIN.
- S_DRAIN (old request still outstanding): im_req stays 1 on the old address.
  - Further flushes overwrite F_pc with flush_pc.
  - On im_ack: discard the data; im_addr<=F_pc (or flush_pc if flush is asserted the same cycle), im_req stays 1, go to S_REQ.
- S_HOLD: F_valid=1 and outputs hold steady while stall=1.
  - accept: F_pc<=npc, im_addr<=npc, im_req<=1, F_valid<=0, go to S_REQ.
  - flush: F_valid<=0, F_pc<=flush_pc, im_addr<=flush_pc, im_req<=1, go to S_REQ.
- Latency: from the im_ack edge, F_valid=1 the next cycle. From the accept edge, the next im_req=1 the next cycle. With a zero-wait memory this gives 1 instruction per 2 cycles.
- Delay-slot semantics are preserved: npc is consumed only on accept, so every fetched word reaches D unless a flush occurs.
- F_pc is 32-bit and wraps modulo 2^32; the block does no arithmetic on it.
- F_exc is always 0 without the optional feature.

Optional Feature:
- Macro: FETCH_ADDR_CHECK_EN.
- Enabled: a target address is faulting if addr[1:0]!=0 or addr is outside [RESET_PC, RESET_PC+IM_SIZE).
  - When entering S_REQ with a faulting target, no request is issued: im_req stays 0.
  - Next cycle: F_instr=0 (nop), F_exc=5'd4 (AdEL), F_valid=1, state=S_HOLD.
  - accept or flush clears F_exc to 0.
- Disabled: no check is made, every address is requested as-is, and F_exc is tied to 0.

Test Plan:
1. Reset low 3 cycles, then release; memory acks 1 cycle after req with 32'h2408_0001 -> im_req=1 and im_addr=32'h3000 in cycle 2; F_valid=1, F_instr=32'h2408_0001, F_pc=32'h3000 one cycle after the ack.
2. F_valid=1, stall=1 for 4 cycles, npc=32'h3004 -> F_pc and F_instr held and no new im_req; after stall drops, im_req=1 with im_addr=32'h3004 the next cycle.
3. Memory withholds im_ack for 5 cycles -> im_req and im_addr=32'h3004 stable throughout; the single ack produces exactly one F_valid.
4. flush with flush_pc=32'h4180 while in S_REQ with ack pending -> im_addr stays at the old address until ack; that data is dropped (F_valid stays 0); next request is to 32'h4180 and F_pc=32'h4180.
5. flush and stall=0 in the same cycle as F_valid=1, npc=32'h3008 -> npc is ignored; next im_addr=32'h4180.
6. FETCH_ADDR_CHECK_EN on, npc=32'h3002 accepted -> im_req stays 0; F_valid=1, F_exc=4, F_instr=0; a flush to 32'h4180 clears F_exc to 0.

Source files
------------

// File: rtl/f_fetch_ctrl.sv
// f_fetch_ctrl: F-stage fetch sequencer. Owns F_pc, fetches instruction words
// over a req/ack handshake, presents them to D until accepted, and applies
// redirects (flush) from later stages.
// Optional feature macro: FETCH_ADDR_CHECK_EN. When it is defined, misaligned
// or out-of-range fetch targets raise AdEL (F_exc=4) instead of issuing a request.
//
// state   | meaning
// S_IDLE  | first cycle after reset release; launches the fetch of F_pc
// S_REQ   | request outstanding for F_pc (or faulting target: no request, AdEL next)
// S_DRAIN | redirected while a stale request is outstanding; drop its ack
// S_HOLD  | word presented to D; wait for accept or flush
module f_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic [4:0]  F_exc
);

`ifdef FETCH_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HOLD} state_t;

  state_t      state;
  logic        fault_pend;
  logic        accept;
  logic        go_req;
  logic        tgt_fault;
  logic [31:0] tgt;

  // Range is evaluated in 33 bits so RESET_PC+IM_SIZE cannot wrap.
  function automatic logic addr_fault(input logic [31:0] a);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, RESET_PC};
    hi = lo + {1'b0, IM_SIZE};
    return CHECK_EN && ((a[1:0] != 2'b00) || ({1'b0, a} < lo) || ({1'b0, a} >= hi));
  endfunction

  assign accept = F_valid & ~stall & ~flush;

  // Decide whether a new fetch target is launched this cycle, and which one.
  always_comb begin
    go_req = 1'b0;
    tgt    = F_pc;
    case (state)
      S_IDLE: begin
        go_req = 1'b1;
        tgt    = flush ? flush_pc : F_pc;
      end
      S_REQ: begin
        if (flush && (fault_pend || im_ack)) begin
          go_req = 1'b1;
          tgt    = flush_pc;
        end
      end
      S_DRAIN: begin
        if (im_ack) begin
          go_req = 1'b1;
          tgt    = flush ? flush_pc : F_pc;
        end
      end
      S_HOLD: begin
        if (flush) begin
          go_req = 1'b1;
          tgt    = flush_pc;
        end else if (accept) begin
          go_req = 1'b1;
          tgt    = npc;
        end
      end
      default: ;
    endcase
    tgt_fault = addr_fault(tgt);
  end

  // Sequencer state, handshake outputs and the registered D-side interface.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      fault_pend <= 1'b0;
      im_req     <= 1'b0;
      im_addr    <= RESET_PC;
      F_pc       <= RESET_PC;
      F_instr    <= 32'h0;
      F_valid    <= 1'b0;
      F_exc      <= 5'd0;
    end else if (go_req) begin
      // A faulting target never reaches memory; it is reported one cycle later.
      state      <= S_REQ;
      im_addr    <= tgt;
      im_req     <= ~tgt_fault;
      fault_pend <= tgt_fault;
      F_pc       <= tgt;
      F_valid    <= 1'b0;
      F_exc      <= 5'd0;
    end else begin
      case (state)
        S_REQ: begin
          if (fault_pend) begin
            fault_pend <= 1'b0;
            F_instr    <= 32'h0;
            F_exc      <= EXC_ADEL;
            F_valid    <= 1'b1;
            state      <= S_HOLD;
          end else if (im_ack) begin
            F_instr <= im_rdata;
            F_valid <= 1'b1;
            im_req  <= 1'b0;
            state   <= S_HOLD;
          end else if (flush) begin
            // Old request must still complete on its original address.
            F_pc  <= flush_pc;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (flush) F_pc <= flush_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Self-checking bench for f_fetch_ctrl: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch sequence.
module tb_f_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset, stall, flush, im_ack, im_req, F_valid;
  logic [31:0] npc, flush_pc, im_rdata, im_addr, F_pc, F_instr;
  logic [4:0]  F_exc;

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 1;
  int mcnt   = 0;
  bit rand_lat = 1'b0;
  bit spur     = 1'b0;

  f_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .npc(npc), .flush(flush),
    .flush_pc(flush_pc), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
    .im_rdata(im_rdata), .F_pc(F_pc), .F_instr(F_instr), .F_valid(F_valid),
    .F_exc(F_exc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0001;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [11:0] w;
    w = 12'($urandom_range(0, 4095));
    return 32'h0000_3000 + {18'd0, w, 2'b00};
  endfunction

  // Advance to the next falling edge and play the memory side for this cycle.
  task automatic step();
    @(negedge clk);
    if (im_req) begin
      if (mcnt >= lat) begin
        im_ack   = 1'b1;
        im_rdata = mem_word(im_addr);
        mcnt     = 0;
        if (rand_lat) lat = int'($urandom_range(0, 3));
      end else begin
        im_ack   = 1'b0;
        im_rdata = 32'h0;
        mcnt++;
      end
    end else begin
      mcnt     = 0;
      im_ack   = spur && ($urandom_range(0, 2) == 0);
      im_rdata = 32'hDEAD_BEEF;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; npc = 32'h0; flush_pc = 32'h0;
    im_ack = 1'b0; im_rdata = 32'h0;
    #1 reset = 1'b0;
    #1;
    n_chk++;
    if ({F_pc, im_req, F_valid} !== {32'h3000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", {F_pc, im_req, F_valid}, {32'h3000, 1'b0, 1'b0});
    end
    repeat (3) step();
    n_chk++;
    if ({im_req, im_addr, F_pc, F_valid, F_instr, F_exc} !== {1'b0, 32'h3000, 32'h3000, 1'b0, 32'h0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", {im_req, im_addr, F_pc, F_valid, F_instr, F_exc},
               {1'b0, 32'h3000, 32'h3000, 1'b0, 32'h0, 5'd0});
    end
    reset = 1'b1;
  endtask

  task automatic test_first_fetch();
    lat = 1;
    step();
    n_chk++;
    if ({im_req, im_addr, F_valid} !== {1'b1, 32'h3000, 1'b0}) begin
      n_fail++;
      $display("FAIL first_req: got %h expected %h", {im_req, im_addr, F_valid}, {1'b1, 32'h3000, 1'b0});
    end
    step();
    n_chk++;
    if ({im_req, im_addr, F_valid} !== {1'b1, 32'h3000, 1'b0}) begin
      n_fail++;
      $display("FAIL first_req_hold: got %h expected %h", {im_req, im_addr, F_valid}, {1'b1, 32'h3000, 1'b0});
    end
    step();
    n_chk++;
    if ({F_valid, F_instr, F_pc, im_req} !== {1'b1, 32'h2408_0001, 32'h3000, 1'b0}) begin
      n_fail++;
      $display("FAIL first_present: got %h expected %h", {F_valid, F_instr, F_pc, im_req},
               {1'b1, 32'h2408_0001, 32'h3000, 1'b0});
    end
  endtask

  task automatic test_stall();
    lat = 5;
    npc = 32'h3004;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++;
      if ({F_valid, F_pc, F_instr, im_req} !== {1'b1, 32'h3000, 32'h2408_0001, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, {F_valid, F_pc, F_instr, im_req},
                 {1'b1, 32'h3000, 32'h2408_0001, 1'b0});
      end
    end
    stall = 1'b0;
    step();
    stall = 1'b1;
    n_chk++;
    if ({im_req, im_addr, F_pc, F_valid} !== {1'b1, 32'h3004, 32'h3004, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_release: got %h expected %h", {im_req, im_addr, F_pc, F_valid},
               {1'b1, 32'h3004, 32'h3004, 1'b0});
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if ({im_req, im_addr, F_valid} !== {1'b1, 32'h3004, 1'b0}) begin
        n_fail++;
        $display("FAIL wait_stable[%0d]: got %h expected %h", i, {im_req, im_addr, F_valid}, {1'b1, 32'h3004, 1'b0});
      end
    end
    step();
    n_chk++;
    if ({F_valid, F_instr, F_pc, im_req} !== {1'b1, mem_word(32'h3004), 32'h3004, 1'b0}) begin
      n_fail++;
      $display("FAIL wait_present: got %h expected %h", {F_valid, F_instr, F_pc, im_req},
               {1'b1, mem_word(32'h3004), 32'h3004, 1'b0});
    end
    step();
    n_chk++;
    if ({F_valid, F_pc, im_req} !== {1'b1, 32'h3004, 1'b0}) begin
      n_fail++;
      $display("FAIL wait_single: got %h expected %h", {F_valid, F_pc, im_req}, {1'b1, 32'h3004, 1'b0});
    end
  endtask

  task automatic test_flush_pending();
    bit seen;
    lat = 3;
    npc = 32'h3008;
    stall = 1'b0;
    step();
    flush = 1'b1; flush_pc = 32'h4180;
    step();
    flush = 1'b0;
    n_chk++;
    if ({im_req, im_addr, F_pc, F_valid} !== {1'b1, 32'h3008, 32'h4180, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_entry: got %h expected %h", {im_req, im_addr, F_pc, F_valid},
               {1'b1, 32'h3008, 32'h4180, 1'b0});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++;
      if ({im_req, im_addr} !== {1'b1, 32'h3008}) begin
        n_fail++;
        $display("FAIL drain_stable[%0d]: got %h expected %h", i, {im_req, im_addr}, {1'b1, 32'h3008});
      end
    end
    step();
    n_chk++;
    if ({im_req, im_addr, F_valid, F_pc} !== {1'b1, 32'h4180, 1'b0, 32'h4180}) begin
      n_fail++;
      $display("FAIL drain_redirect: got %h expected %h", {im_req, im_addr, F_valid, F_pc},
               {1'b1, 32'h4180, 1'b0, 32'h4180});
    end
    seen = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = F_valid;
    end
    n_chk++;
    if ({seen, F_pc, F_instr} !== {1'b1, 32'h4180, mem_word(32'h4180)}) begin
      n_fail++;
      $display("FAIL drain_present: got %h expected %h", {seen, F_pc, F_instr}, {1'b1, 32'h4180, mem_word(32'h4180)});
    end
  endtask

  task automatic test_flush_accept();
    lat = 0;
    npc = 32'h3008; stall = 1'b0; flush = 1'b1; flush_pc = 32'h4180;
    step();
    flush = 1'b0; stall = 1'b1;
    n_chk++;
    if ({im_req, im_addr, F_pc, F_valid} !== {1'b1, 32'h4180, 32'h4180, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_over_accept: got %h expected %h", {im_req, im_addr, F_pc, F_valid},
               {1'b1, 32'h4180, 32'h4180, 1'b0});
    end
    step();
    n_chk++;
    if ({F_valid, F_pc, F_instr} !== {1'b1, 32'h4180, mem_word(32'h4180)}) begin
      n_fail++;
      $display("FAIL flush_refetch: got %h expected %h", {F_valid, F_pc, F_instr}, {1'b1, 32'h4180, mem_word(32'h4180)});
    end
  endtask

  task automatic test_addr_check();
    lat = 0;
    npc = 32'h3002; stall = 1'b0;
    step();
    stall = 1'b1;
`ifdef FETCH_ADDR_CHECK_EN
    n_chk++;
    if ({im_req, F_valid} !== {1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL adel_no_req: got %h expected %h", {im_req, F_valid}, 2'b00);
    end
    step();
    n_chk++;
    if ({F_valid, F_exc, F_instr, F_pc, im_req} !== {1'b1, 5'd4, 32'h0, 32'h3002, 1'b0}) begin
      n_fail++;
      $display("FAIL adel_present: got %h expected %h", {F_valid, F_exc, F_instr, F_pc, im_req},
               {1'b1, 5'd4, 32'h0, 32'h3002, 1'b0});
    end
    flush = 1'b1; flush_pc = 32'h4180;
    step();
    flush = 1'b0;
    n_chk++;
    if ({F_exc, F_valid, im_req, im_addr} !== {5'd0, 1'b0, 1'b1, 32'h4180}) begin
      n_fail++;
      $display("FAIL adel_clear: got %h expected %h", {F_exc, F_valid, im_req, im_addr}, {5'd0, 1'b0, 1'b1, 32'h4180});
    end
    step();
    npc = 32'h7000; stall = 1'b0;
    step();
    stall = 1'b1;
    step();
    n_chk++;
    if ({F_valid, F_exc, F_pc} !== {1'b1, 5'd4, 32'h7000}) begin
      n_fail++;
      $display("FAIL adel_range: got %h expected %h", {F_valid, F_exc, F_pc}, {1'b1, 5'd4, 32'h7000});
    end
`else
    n_chk++;
    if ({im_req, im_addr} !== {1'b1, 32'h3002}) begin
      n_fail++;
      $display("FAIL nocheck_req: got %h expected %h", {im_req, im_addr}, {1'b1, 32'h3002});
    end
    step();
    n_chk++;
    if ({F_valid, F_exc, F_pc, F_instr} !== {1'b1, 5'd0, 32'h3002, mem_word(32'h3002)}) begin
      n_fail++;
      $display("FAIL nocheck_present: got %h expected %h", {F_valid, F_exc, F_pc, F_instr},
               {1'b1, 5'd0, 32'h3002, mem_word(32'h3002)});
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, p_addr, p_npc, p_fpc;
    logic        p_req, p_ack, p_valid, p_stall, p_flush;
    int          n_pres;
    rand_lat = 1'b1; spur = 1'b1; n_pres = 0;
    step();
    flush = 1'b1; flush_pc = rand_addr(); stall = 1'b0;
    exp_pc = flush_pc;
    p_req = im_req; p_ack = im_ack; p_addr = im_addr; p_valid = F_valid;
    p_stall = stall; p_flush = 1'b1; p_npc = npc; p_fpc = flush_pc;
    for (int c = 0; c < 600; c++) begin
      step();
      if (F_valid) begin
        n_chk++;
        if ({F_pc, F_instr, F_exc} !== {exp_pc, mem_word(exp_pc), 5'd0}) begin
          n_fail++;
          $display("FAIL rnd_present@%0d: got %h expected %h", c, {F_pc, F_instr, F_exc}, {exp_pc, mem_word(exp_pc), 5'd0});
        end
      end
      if (p_req && !p_ack) begin
        n_chk++;
        if ({im_req, im_addr} !== {1'b1, p_addr}) begin
          n_fail++;
          $display("FAIL rnd_handshake@%0d: got %h expected %h", c, {im_req, im_addr}, {1'b1, p_addr});
        end
      end
      if (p_valid && !p_stall && !p_flush) begin
        n_chk++;
        if ({im_req, im_addr, F_valid} !== {1'b1, p_npc, 1'b0}) begin
          n_fail++;
          $display("FAIL rnd_accept@%0d: got %h expected %h", c, {im_req, im_addr, F_valid}, {1'b1, p_npc, 1'b0});
        end
      end
      if (p_flush) begin
        n_chk++;
        if ({F_pc, F_valid} !== {p_fpc, 1'b0}) begin
          n_fail++;
          $display("FAIL rnd_flush@%0d: got %h expected %h", c, {F_pc, F_valid}, {p_fpc, 1'b0});
        end
      end
      if (F_valid && !p_valid) begin
        n_chk++;
        if ({p_req, p_ack, p_flush} !== 3'b110) begin
          n_fail++;
          $display("FAIL rnd_rise@%0d: got %b expected %b", c, {p_req, p_ack, p_flush}, 3'b110);
        end
      end
      stall    = ($urandom_range(0, 9) < 4);
      flush    = ($urandom_range(0, 19) == 0);
      flush_pc = rand_addr();
      if (!F_valid) npc = rand_addr();
      if (flush) exp_pc = flush_pc;
      else if (F_valid && !stall) begin
        exp_pc = npc;
        n_pres++;
      end
      p_req = im_req; p_ack = im_ack; p_addr = im_addr; p_valid = F_valid;
      p_stall = stall; p_flush = flush; p_npc = npc; p_fpc = flush_pc;
    end
    flush = 1'b0;
    n_chk++;
    if (n_pres < 20) begin
      n_fail++;
      $display("FAIL rnd_progress: got %0d accepted, required at least 20", n_pres);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_wait_states();
    test_flush_pending();
    test_flush_accept();
    test_addr_check();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
